// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, response-entry layout and the compute function.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] ans;
        logic                 carry;
        logic                 zero;
    } rsp_entry_t;

    // Arithmetic runs one bit wider than the operands; the top bit is carry/borrow.
    function automatic rsp_entry_t alu_compute(input logic [ALU_WIDTH-1:0] a,
                                               input logic [ALU_WIDTH-1:0] b,
                                               input logic [1:0]           op);
        logic [ALU_WIDTH:0] wide;
        rsp_entry_t         res;
        unique case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_AND:  wide = {1'b0, a & b};
            default: wide = {1'b0, a | b};
        endcase
        res.ans   = wide[ALU_WIDTH-1:0];
        res.carry = wide[ALU_WIDTH];
        res.zero  = (wide[ALU_WIDTH-1:0] == '0);
        return res;
    endfunction

endpackage

// File: rtl/alu_rsp_fifo.sv
// Generic synchronous FIFO; read data is forced to zero while empty.
module alu_rsp_fifo #(
    parameter int unsigned DataWidth = 6,
    parameter int unsigned Depth     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] wdata_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrW = $clog2(Depth);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wptr_q, wptr_d;
    logic [PtrW-1:0]      rptr_q, rptr_d;
    logic [PtrW:0]        count_q, count_d;

    assign full_o  = (count_q == (PtrW+1)'(Depth));
    assign empty_o = (count_q == '0);
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];

    // Next-state pointers and occupancy; push and pop together leave count unchanged.
    always_comb begin
        wptr_d  = push_i ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d  = pop_i  ? rptr_q + PtrW'(1) : rptr_q;
        count_d = count_q;
        unique case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PtrW+1)'(1);
            2'b01:   count_d = count_q - (PtrW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state; reset drops every entry at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: reads are masked by empty_o.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_req_responder.sv
// Flow-controlled ALU service: requests are computed on accept and queued as responses.
module alu_req_responder
    import alu_pkg::*;
#(
    // Must match alu_pkg::ALU_WIDTH, which sizes the response entry.
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [1:0]       req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_ans,
    output logic             rsp_carry,
    output logic             rsp_zero,
    output logic [CNTW-1:0]  op_count,
    output logic             busy
);

    rsp_entry_t      wr_entry;
    rsp_entry_t      rd_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic [CNTW-1:0] op_count_q, op_count_d;

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    always_comb begin
        rsp_valid = !fifo_empty;
        pop       = rsp_valid && rsp_ready;
        req_ready = !fifo_full || pop;
        push      = req_valid && req_ready;
        wr_entry  = alu_compute(req_a, req_b, req_op);
        op_count_d = pop ? op_count_q + CNTW'(1) : op_count_q;
    end

    alu_rsp_fifo #(
        .DataWidth($bits(rsp_entry_t)),
        .Depth    (DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .push_i (push),
        .wdata_i(wr_entry),
        .pop_i  (pop),
        .rdata_o(rd_entry),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // Completed-response counter, wraps without saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign rsp_ans   = rd_entry.ans;
    assign rsp_carry = rd_entry.carry;
    assign rsp_zero  = rd_entry.zero;
    assign op_count  = op_count_q;
    assign busy      = !fifo_empty;

endmodule

// File: tb/tb_alu_req_responder.sv
// Scoreboard bench: driver queues expected responses on accept, monitor checks on pop.
module tb_alu_req_responder;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_a = '0;
    logic [3:0] req_b = '0;
    logic [1:0] req_op = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_ans;
    logic       rsp_carry;
    logic       rsp_zero;
    logic [7:0] op_count;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_pops  = 0;
    logic [5:0] exp_q [$];

    alu_req_responder #(
        .WIDTH(4),
        .DEPTH(DEPTH),
        .CNTW (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .req_op   (req_op),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_ans  (rsp_ans),
        .rsp_carry(rsp_carry),
        .rsp_zero (rsp_zero),
        .op_count (op_count),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic; packs {ans, carry, zero}.
    function automatic logic [5:0] model(input int a, input int b, input int op);
        int ans;
        int carry;
        case (op)
            0: begin ans = (a + b) % 16; carry = (a + b) > 15 ? 1 : 0; end
            1: begin ans = (a - b + 16) % 16; carry = (a < b) ? 1 : 0; end
            2: begin ans = a & b; carry = 0; end
            default: begin ans = a | b; carry = 0; end
        endcase
        return {ans[3:0], carry[0], (ans == 0)};
    endfunction

    // Monitor: checks handshake state and pops the scoreboard on every response.
    always @(negedge clk) begin
        if (rst_n) begin
            logic [5:0] e;
            int sz;
            sz = exp_q.size();
            check("rsp_valid", rsp_valid, sz > 0);
            check("busy", busy, sz > 0);
            check("req_ready", req_ready, (sz < DEPTH) || (sz > 0 && rsp_ready));
            check("op_count", op_count, n_pops % 256);
            if (sz == 0) check("empty_ans", {rsp_ans, rsp_carry, rsp_zero}, 0);
            if (rsp_valid && rsp_ready) begin
                if (sz == 0) begin
                    check("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_ans", rsp_ans, e[5:2]);
                    check("rsp_carry", rsp_carry, e[1]);
                    check("rsp_zero", rsp_zero, e[0]);
                end
                n_pops++;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        exp_q.delete();
        n_pops = 0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    // Presents one request and waits (bounded) for it to be accepted.
    task automatic send(input int a, input int b, input int op);
        int   waited = 0;
        logic acc = 1'b0;
        req_a = 4'(a);
        req_b = 4'(b);
        req_op = 2'(op);
        req_valid = 1'b1;
        while (!acc && waited < 50) begin
            @(negedge clk);
            acc = req_valid && req_ready;
            #1;
            if (acc) exp_q.push_back(model(a, b, op));
            cycle();
            waited++;
        end
        req_valid = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int waited = 0;
        rsp_ready = 1'b1;
        while (exp_q.size() != 0 && waited < 100) begin
            cycle();
            waited++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        cycle();
    endtask

    initial begin
        int accepted;
        int guard;
        logic acc;

        // 1. Reset state
        do_reset();
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_op_count", op_count, 0);
        check("rst_busy", busy, 0);

        // 2. Single OR request
        rsp_ready = 1'b1;
        send(1, 1, 3);
        check("or_valid", rsp_valid, 1);
        check("or_ans", {rsp_ans, rsp_carry, rsp_zero}, {4'h1, 1'b0, 1'b0});
        cycle();
        check("or_count", op_count, 1);

        // 3. Fill with consumer stalled
        rsp_ready = 1'b0;
        send(15, 1, 0);
        send(3, 5, 1);
        send(6, 9, 2);
        send(0, 0, 3);
        @(negedge clk);
        check("full_ready", req_ready, 0);
        check("full_head", {rsp_ans, rsp_carry, rsp_zero}, {4'h0, 1'b1, 1'b1});
        cycle();
        check("hold_head", {rsp_ans, rsp_carry, rsp_zero}, {4'h0, 1'b1, 1'b1});

        // 4. Push and pop together while full
        rsp_ready = 1'b1;
        send(7, 2, 1);
        rsp_ready = 1'b0;
        @(negedge clk);
        check("full_after_pp", req_ready, 0);
        check("head_after_pp", {rsp_ans, rsp_carry, rsp_zero}, {4'hE, 1'b1, 1'b0});
        cycle();
        drain();
        check("after_drain_count", op_count, 6);

        // 5. 2^CNTW+3 random transactions from reset
        do_reset();
        accepted = 0;
        guard = 0;
        while (accepted < 259 && guard < 5000) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            req_valid = $urandom_range(0, 1) != 0;
            req_a = 4'($urandom_range(0, 15));
            req_b = 4'($urandom_range(0, 15));
            req_op = 2'($urandom_range(0, 3));
            @(negedge clk);
            acc = req_valid && req_ready;
            #1;
            if (acc) begin
                exp_q.push_back(model(int'(req_a), int'(req_b), int'(req_op)));
                accepted++;
            end
            cycle();
            guard++;
        end
        req_valid = 1'b0;
        check("random_accepted", accepted, 259);
        drain();
        check("wrap_count", op_count, 3);

        // 6. Reset with entries queued
        rsp_ready = 1'b0;
        send(2, 2, 0);
        send(9, 4, 1);
        send(5, 3, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", rsp_valid, 0);
        check("async_rst_busy", busy, 0);
        exp_q.delete();
        n_pops = 0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        rsp_ready = 1'b1;
        send(2, 3, 0);
        check("post_rst_ans", {rsp_ans, rsp_carry, rsp_zero}, {4'h5, 1'b0, 1'b0});
        drain();
        check("post_rst_count", op_count, 1);
        check("post_rst_empty", rsp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
